multicyc_mcu: RTL and testbench

MULTICYC_MCU -- requirements
Module: multicyc_mcu

---
 rtl/multicyc_mcu_pkg.sv | 52 +++++
 rtl/multicyc_mcu.sv | 190 +++++++++++++++++++
 tb/tb_multicyc_mcu.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicyc_mcu_pkg.sv
// Shared definitions for the multi-cycle MCU control unit.
//   Opcodes      : Instr[31:26] values recognised by the decoder.
//   ALUops       : 4-bit ALU operation codes driven on aluop.
//   MulticycCtrl : controller state enum plus the encodings used on
//                  alu_srcb_sel, pc_src_sel and iord.
// No ports; this file only holds packages.

package Opcodes;
  localparam logic [5:0] OP_RR    = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
endpackage

package ALUops;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  // RR: the ALU decodes the function field itself.
  localparam logic [3:0] ALU_RR   = 4'd8;
endpackage

package MulticycCtrl;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RREXE  = 4'd6,
    IMMEXE = 4'd7,
    ALUWB  = 4'd8,
    BEQ    = 4'd9,
    JMP    = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_SHL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;
endpackage

// File: rtl/multicyc_mcu.sv
// Multi-cycle MCU control unit: a Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps for a small MIPS-like subset.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   opcode[5:0]          Instr[31:26] from the instruction register
//   mem_ready            memory completes the current access this cycle
//   zero                 ALU zero flag (branch condition)
//   pc_we, ir_we, iord, mem_re, mem_we, reg_we   datapath strobes
//   wreg_dst_sel, wrbck_data_sel, alu_srca_sel   datapath muxes
//   alu_srcb_sel[1:0], pc_src_sel[1:0], aluop[3:0]
//   illegal_op           one-cycle pulse in the FETCH after an unknown opcode
//   retired[31:0]        instructions completed (only with MULTICYC_PERF_CNT_EN)
//   state_dbg            current controller state, for observation
//
// Memory handshake: while in FETCH, MEMRD or MEMWR the controller holds its
// request (mem_re or mem_we) and its address select steady every cycle; the
// access completes, and the FSM advances, in the first cycle with
// mem_ready=1. mem_ready is ignored in all other states.
//
// Optional feature macro: MULTICYC_PERF_CNT_EN adds the retired counter.

module multicyc_mcu
  import MulticycCtrl::*;
  import Opcodes::*;
  import ALUops::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic        iord,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        wreg_dst_sel,
  output logic        wrbck_data_sel,
  output logic        alu_srca_sel,
  output logic [1:0]  alu_srcb_sel,
  output logic [1:0]  pc_src_sel,
  output logic [3:0]  aluop,
  output logic        illegal_op,
`ifdef MULTICYC_PERF_CNT_EN
  output logic [31:0] retired,
`endif
  output state_t      state_dbg
);

  state_t state, next_state;
  logic   is_rr_q;
  logic   is_addiu_q;
  logic   illegal_q;
  logic   pc_we_raw, ir_we_raw, mem_we_raw, reg_we_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      is_rr_q    <= 1'b0;
      is_addiu_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state <= next_state;
      // Instruction class is latched in DECODE so later states decode from
      // registers only.
      if (state == DECODE) begin
        is_rr_q    <= (opcode == OP_RR);
        is_addiu_q <= (opcode == OP_ADDIU);
      end
      // DECODE only falls back to FETCH for an unknown opcode.
      illegal_q <= (state == DECODE) && (next_state == FETCH);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     next_state = MEMADR;
          OP_RR:            next_state = RREXE;
          OP_ADDI, OP_ADDIU: next_state = IMMEXE;
          OP_BEQ:           next_state = BEQ;
          OP_J:             next_state = JMP;
          default:          next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) next_state = MEMWB;
      MEMWB:  next_state = FETCH;
      MEMWR:  if (mem_ready) next_state = FETCH;
      RREXE:  next_state = ALUWB;
      IMMEXE: next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BEQ:    next_state = FETCH;
      JMP:    next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_we_raw      = 1'b0;
    ir_we_raw      = 1'b0;
    mem_we_raw     = 1'b0;
    reg_we_raw     = 1'b0;
    iord           = IORD_PC;
    mem_re         = 1'b0;
    wreg_dst_sel   = 1'b0;
    wrbck_data_sel = 1'b0;
    alu_srca_sel   = 1'b0;
    alu_srcb_sel   = SRCB_RT;
    pc_src_sel     = PCSRC_ALU;
    aluop          = ALU_ADD;
    case (state)
      FETCH: begin
        mem_re       = 1'b1;
        alu_srcb_sel = SRCB_FOUR;
        // PC+4 and IR load only in the cycle the instruction word arrives.
        ir_we_raw    = mem_ready;
        pc_we_raw    = mem_ready;
      end
      DECODE: alu_srcb_sel = SRCB_SHL2;
      MEMADR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = SRCB_SEXT;
      end
      MEMRD: begin
        mem_re = 1'b1;
        iord   = IORD_ALUOUT;
      end
      MEMWB: begin
        reg_we_raw     = 1'b1;
        wrbck_data_sel = 1'b1;
      end
      MEMWR: begin
        mem_we_raw = 1'b1;
        iord       = IORD_ALUOUT;
      end
      RREXE: begin
        alu_srca_sel = 1'b1;
        aluop        = ALU_RR;
      end
      IMMEXE: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = SRCB_SEXT;
        aluop        = is_addiu_q ? ALU_ADDU : ALU_ADD;
      end
      ALUWB: begin
        reg_we_raw   = 1'b1;
        wreg_dst_sel = is_rr_q;
      end
      BEQ: begin
        alu_srca_sel = 1'b1;
        aluop        = ALU_SUB;
        pc_src_sel   = PCSRC_ALUOUT;
        pc_we_raw    = zero;
      end
      JMP: begin
        pc_src_sel = PCSRC_JUMP;
        pc_we_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are qualified by rst_n so that no write escapes while reset
  // is held, even though FETCH still reacts to mem_ready.
  assign pc_we      = pc_we_raw  & rst_n;
  assign ir_we      = ir_we_raw  & rst_n;
  assign mem_we     = mem_we_raw & rst_n;
  assign reg_we     = reg_we_raw & rst_n;
  assign illegal_op = illegal_q;
  assign state_dbg  = state;

`ifdef MULTICYC_PERF_CNT_EN
  // Counts entries into FETCH from a completing state; DECODE->FETCH is the
  // illegal-opcode path and is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= 32'd0;
    end else if ((state != FETCH) && (state != DECODE) && (next_state == FETCH)) begin
      retired <= retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicyc_mcu.sv
// Self-checking bench for multicyc_mcu: directed instruction sequences,
// reset scenarios and a randomized instruction stream, all checked against
// an instruction-level model (state path per opcode, per-state control
// table, cycle/strobe totals, retired count).

module tb_multicyc_mcu;
  import MulticycCtrl::*;
  import Opcodes::*;
  import ALUops::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        zero;
  logic        pc_we, ir_we, iord, mem_re, mem_we, reg_we;
  logic        wreg_dst_sel, wrbck_data_sel, alu_srca_sel;
  logic [1:0]  alu_srcb_sel, pc_src_sel;
  logic [3:0]  aluop;
  logic        illegal_op;
  state_t      state_dbg;
`ifdef MULTICYC_PERF_CNT_EN
  logic [31:0] retired;
  int          exp_retired;
`endif

  logic [16:0] ctrl_obs;
  assign ctrl_obs = {pc_we, ir_we, iord, mem_re, mem_we, reg_we, wreg_dst_sel,
                     wrbck_data_sel, alu_srca_sel, alu_srcb_sel, pc_src_sel, aluop};

  int     n_cmp;
  int     n_fail;
  bit     pending_illegal;
  state_t exp_q[$];

  multicyc_mcu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode         (opcode),
    .mem_ready      (mem_ready),
    .zero           (zero),
    .pc_we          (pc_we),
    .ir_we          (ir_we),
    .iord           (iord),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .reg_we         (reg_we),
    .wreg_dst_sel   (wreg_dst_sel),
    .wrbck_data_sel (wrbck_data_sel),
    .alu_srca_sel   (alu_srca_sel),
    .alu_srcb_sel   (alu_srcb_sel),
    .pc_src_sel     (pc_src_sel),
    .aluop          (aluop),
    .illegal_op     (illegal_op),
`ifdef MULTICYC_PERF_CNT_EN
    .retired        (retired),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RR) || (op == OP_ADDI) ||
           (op == OP_ADDIU) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      OP_LW:                     return 5;
      OP_SW:                     return 4;
      OP_RR, OP_ADDI, OP_ADDIU:  return 4;
      OP_BEQ, OP_J:              return 3;
      default:                   return 2;
    endcase
  endfunction

  task automatic build_path(input logic [5:0] op);
    exp_q.delete();
    exp_q.push_back(FETCH);
    exp_q.push_back(DECODE);
    case (op)
      OP_LW:   begin exp_q.push_back(MEMADR); exp_q.push_back(MEMRD); exp_q.push_back(MEMWB); end
      OP_SW:   begin exp_q.push_back(MEMADR); exp_q.push_back(MEMWR); end
      OP_RR:   begin exp_q.push_back(RREXE);  exp_q.push_back(ALUWB); end
      OP_ADDI, OP_ADDIU: begin exp_q.push_back(IMMEXE); exp_q.push_back(ALUWB); end
      OP_BEQ:  exp_q.push_back(BEQ);
      OP_J:    exp_q.push_back(JMP);
      default: ;
    endcase
  endtask

  // Control vector per state, in the same field order as ctrl_obs.
  function automatic logic [16:0] exp_ctrl(input state_t s, input logic mr, input logic z,
                                           input logic rr, input logic addiu);
    logic pw, iw, io, re, we, rw, dst, wb, sa;
    logic [1:0] sb, ps;
    logic [3:0] op;
    pw = 0; iw = 0; io = 0; re = 0; we = 0; rw = 0; dst = 0; wb = 0; sa = 0;
    sb = 2'd0; ps = 2'd0; op = ALU_ADD;
    case (s)
      FETCH:  begin re = 1; sb = 2'd1; pw = mr; iw = mr; end
      DECODE: sb = 2'd3;
      MEMADR: begin sa = 1; sb = 2'd2; end
      MEMRD:  begin re = 1; io = 1; end
      MEMWB:  begin rw = 1; wb = 1; end
      MEMWR:  begin we = 1; io = 1; end
      RREXE:  begin sa = 1; sb = 2'd0; op = ALU_RR; end
      IMMEXE: begin sa = 1; sb = 2'd2; op = addiu ? ALU_ADDU : ALU_ADD; end
      ALUWB:  begin rw = 1; dst = rr; end
      BEQ:    begin sa = 1; op = ALU_SUB; ps = 2'd1; pw = z; end
      JMP:    begin ps = 2'd2; pw = 1; end
      default: ;
    endcase
    return {pw, iw, io, re, we, rw, dst, wb, sa, sb, ps, op};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk("reset_state", 32'(state_dbg), 32'(FETCH));
    chk("reset_we", {28'd0, pc_we, ir_we, mem_we, reg_we}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pending_illegal = 0;
`ifdef MULTICYC_PERF_CNT_EN
    exp_retired = 0;
    chk("reset_retired", retired, 32'd0);
`endif
  endtask

  // Runs one instruction from its FETCH; entered and left at posedge+1.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fstall, input int mstall);
    state_t s;
    int     stalls, cycles, rw_cnt, mw_cnt, exp_cycles;
    bit     waits, first, mem_op;
    logic   rr, addiu;
    opcode = op;
    zero   = z;
    rr     = (op == OP_RR);
    addiu  = (op == OP_ADDIU);
    mem_op = (op == OP_LW) || (op == OP_SW);
    build_path(op);
    cycles = 0; rw_cnt = 0; mw_cnt = 0; first = 1;
    while (exp_q.size() > 0) begin
      s      = exp_q.pop_front();
      waits  = (s == FETCH) || (s == MEMRD) || (s == MEMWR);
      stalls = (s == FETCH) ? fstall : (((s == MEMRD) || (s == MEMWR)) ? mstall : 0);
      for (int k = 0; k <= stalls; k++) begin
        if (waits) mem_ready = (k == stalls);
        else       mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("state", 32'(state_dbg), 32'(s));
        chk("ctrl", {15'd0, ctrl_obs}, {15'd0, exp_ctrl(s, mem_ready, zero, rr, addiu)});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, (first && pending_illegal)});
        rw_cnt += int'(reg_we);
        mw_cnt += int'(mem_we);
        first = 0;
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    exp_cycles = base_cycles(op) + fstall + (mem_op ? mstall : 0);
    chk("cycles", 32'(cycles), 32'(exp_cycles));
    chk("reg_we_count", 32'(rw_cnt),
        32'(((op == OP_LW) || (op == OP_RR) || (op == OP_ADDI) || (op == OP_ADDIU)) ? 1 : 0));
    chk("mem_we_count", 32'(mw_cnt), 32'((op == OP_SW) ? (1 + mstall) : 0));
    pending_illegal = !is_legal(op);
`ifdef MULTICYC_PERF_CNT_EN
    if (is_legal(op)) exp_retired++;
    chk("retired", retired, 32'(exp_retired));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    n_cmp = 0;
    n_fail = 0;
    pending_illegal = 0;
    opcode = 6'd0;
    mem_ready = 1'b0;
    zero = 1'b0;
    rst_n = 1'b0;
    legal_ops = '{OP_LW, OP_SW, OP_RR, OP_ADDI, OP_ADDIU, OP_BEQ, OP_J};
    #1;
    do_reset();

    // Directed: each instruction class, stalls, branch both ways, illegal.
    run_instr(OP_LW,    1'b0, 0, 0);
    run_instr(OP_SW,    1'b0, 0, 3);
    run_instr(OP_BEQ,   1'b1, 0, 0);
    run_instr(OP_BEQ,   1'b0, 0, 0);
    run_instr(6'h3F,    1'b0, 0, 0);
    run_instr(OP_RR,    1'b0, 0, 0);
    run_instr(OP_ADDI,  1'b0, 2, 0);
    run_instr(OP_ADDIU, 1'b1, 0, 0);
    run_instr(OP_J,     1'b0, 1, 0);
    run_instr(OP_LW,    1'b0, 1, 2);

    // Reset asserted while a store is stalled in MEMWR.
    opcode = OP_SW; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_state", 32'(state_dbg), 32'(MEMWR));
    chk("memwr_we", {31'd0, mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("async_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("async_rst_state", 32'(state_dbg), 32'(FETCH));
    chk("async_rst_we", {28'd0, pc_we, ir_we, mem_we, reg_we}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    pending_illegal = 0;
`ifdef MULTICYC_PERF_CNT_EN
    exp_retired = 0;
`endif
    @(negedge clk);
    chk("post_rst_state", 32'(state_dbg), 32'(FETCH));
    chk("post_rst_mem_re", {31'd0, mem_re}, 32'd1);
    @(posedge clk);
    #1;

    // Retired count over RR, ADDIU, J, illegal.
    do_reset();
    run_instr(OP_RR,    1'b0, 0, 0);
    run_instr(OP_ADDIU, 1'b0, 0, 0);
    run_instr(OP_J,     1'b0, 0, 0);
    run_instr(6'h3F,    1'b0, 0, 0);
`ifdef MULTICYC_PERF_CNT_EN
    chk("retired_seq", retired, 32'd3);
`endif

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
